// File: rtl/reg_wb_pkg.sv
// Shared types and helpers for the register-file write-back path.
package reg_wb_pkg;

    localparam int XLEN  = 32;
    localparam int REGW  = 5;
    localparam int NREGS = 1 << REGW;

    // One pending register-file write: destination, value, and whether it came from a load.
    typedef struct packed {
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] data;
        logic            is_load;
    } wb_req_t;

    // x0 is hard-wired to zero; writes to it are consumed but never committed.
    function automatic logic is_x0(input logic [REGW-1:0] rd);
        return (rd == '0);
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO that holds load returns until they win the write port.
// Pushes while full and pops while empty are ignored.
module wb_load_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_req_t                 push_req,
    input  logic                    pop,
    output wb_req_t                 head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_req;
    end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Write-port owner for the 32x32 register file: picks one of ALU result or
// buffered load return per cycle, registers it onto A3/WD3/WE3, and tracks
// loads in flight so decode can see RAW hazards on rs1/rs2.
module reg_writeback_arbiter
    import reg_wb_pkg::*;
#(
    parameter int XLEN     = reg_wb_pkg::XLEN,
    parameter int REGW     = reg_wb_pkg::REGW,
    parameter int LQ_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [REGW-1:0]             alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    output logic                        alu_ready,
    input  logic                        ld_issue,
    input  logic [REGW-1:0]             ld_issue_rd,
    input  logic                        ld_valid,
    input  logic [REGW-1:0]             ld_rd,
    input  logic [XLEN-1:0]             ld_data,
    output logic                        ld_ready,
    input  logic [REGW-1:0]             rs1_addr,
    input  logic [REGW-1:0]             rs2_addr,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    output logic [REGW-1:0]             rf_a3,
    output logic [XLEN-1:0]             rf_wd3,
    output logic                        rf_we3,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
);

    localparam int NUM_REGS = 1 << REGW;

    wb_req_t             ld_req;
    wb_req_t             head;
    wb_req_t             win;
    logic                full;
    logic                empty;
    logic                pop;
    logic                alu_take;
    logic                win_vld;
    logic                win_wr;

    logic                vld_p1;
    logic                is_load_p1;
    logic [REGW-1:0]     a3_p1;
    logic [XLEN-1:0]     wd3_p1;
    logic [NUM_REGS-1:0] busy;

    assign ld_req = '{rd: ld_rd, data: ld_data, is_load: 1'b1};

    wb_load_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk      (clk),
        .rst      (rst),
        .push     (ld_valid),
        .push_req (ld_req),
        .pop      (pop),
        .head     (head),
        .count    (lq_count),
        .full     (full),
        .empty    (empty)
    );

    // Readiness comes from registered occupancy only; a same-cycle pop never frees a slot early.
    assign ld_ready  = !full;
    assign alu_ready = !full;

    // Arbitration: a full queue drains first, otherwise ALU, otherwise any queued load.
    always_comb begin
        pop      = full || (!alu_valid && !empty);
        alu_take = alu_valid && !full;
        win_vld  = pop || alu_take;
        win      = pop ? head : '{rd: alu_rd, data: alu_data, is_load: 1'b0};
        win_wr   = win_vld && !is_x0(win.rd);
    end

    // ---- stage p1: registered write port ----
    // Winner lands on the register-file port at the edge; x0 winners are consumed silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            is_load_p1 <= 1'b0;
            a3_p1      <= '0;
            wd3_p1     <= '0;
        end else begin
            vld_p1 <= win_wr;
            if (win_wr) begin
                a3_p1      <= win.rd;
                wd3_p1     <= win.data;
                is_load_p1 <= win.is_load;
            end
        end
    end

    assign rf_we3 = vld_p1;
    assign rf_a3  = a3_p1;
    assign rf_wd3 = wd3_p1;

    // Pending-load scoreboard: cleared when the load's write commits, set on issue; set is last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (vld_p1 && is_load_p1) busy[a3_p1] <= 1'b0;
            if (ld_issue && !is_x0(ld_issue_rd)) busy[ld_issue_rd] <= 1'b1;
        end
    end

    // Hazard view for decode; the in-flight write counts as busy because the file commits on the edge.
    always_comb begin
        rs1_busy = !is_x0(rs1_addr) && (busy[rs1_addr] || (vld_p1 && (a3_p1 == rs1_addr)));
        rs2_busy = !is_x0(rs2_addr) && (busy[rs2_addr] || (vld_p1 && (a3_p1 == rs2_addr)));
    end

    a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
        (ld_issue && !is_x0(ld_issue_rd)) |->
            (!busy[ld_issue_rd] || (vld_p1 && is_load_p1 && (a3_p1 == ld_issue_rd))))
        else $error("load issued to rd %0d while an earlier load to it is pending", ld_issue_rd);

    a_return_pending: assert property (@(posedge clk) disable iff (rst)
        (ld_valid && ld_ready && !is_x0(ld_rd)) |-> busy[ld_rd])
        else $error("load return to rd %0d with no pending load", ld_rd);

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_reg_writeback_arbiter;

    localparam int XLEN     = 32;
    localparam int REGW     = 5;
    localparam int LQ_DEPTH = 2;
    localparam int NR       = 32;
    localparam int CW       = $clog2(LQ_DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [REGW-1:0] alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            ld_issue;
    logic [REGW-1:0] ld_issue_rd;
    logic            ld_valid;
    logic [REGW-1:0] ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic [REGW-1:0] rs1_addr;
    logic [REGW-1:0] rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [REGW-1:0] rf_a3;
    logic [XLEN-1:0] rf_wd3;
    logic            rf_we3;
    logic [CW-1:0]   lq_count;

    always #5 clk = ~clk;

    reg_writeback_arbiter #(
        .XLEN     (XLEN),
        .REGW     (REGW),
        .LQ_DEPTH (LQ_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_a3       (rf_a3),
        .rf_wd3      (rf_wd3),
        .rf_we3      (rf_we3),
        .lq_count    (lq_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: load queue contents, pending/outstanding register sets, and the write port.
    typedef struct {
        int          rd;
        logic [31:0] data;
        bit          is_load;
    } req_t;

    req_t        q[$];
    bit          pend[NR];
    bit          outst[NR];
    bit          m_we;
    int          m_a3;
    logic [31:0] m_wd3;
    bit          m_isload;
    int          wr_log[$];

    bit          seen;
    int          alu_writes;
    int          r;
    int          start;
    int          idx;
    bit          picked;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        bit full;
        bit e1;
        bit e2;
        full = (q.size() == LQ_DEPTH);
        chk("alu_ready", alu_ready, !full);
        chk("ld_ready", ld_ready, !full);
        chk("lq_count", lq_count, q.size());
        chk("rf_we3", rf_we3, m_we);
        if (m_we) begin
            chk("rf_a3", rf_a3, m_a3);
            chk("rf_wd3", rf_wd3, m_wd3);
        end
        e1 = (rs1_addr != 0) && (pend[rs1_addr] || (m_we && m_a3 == int'(rs1_addr)));
        e2 = (rs2_addr != 0) && (pend[rs2_addr] || (m_we && m_a3 == int'(rs2_addr)));
        chk("rs1_busy", rs1_busy, e1);
        chk("rs2_busy", rs2_busy, e2);
        if (rf_we3 === 1'b1) wr_log.push_back(int'(rf_a3));
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NR; i++) begin
            pend[i]  = 1'b0;
            outst[i] = 1'b0;
        end
        m_we     = 1'b0;
        m_a3     = 0;
        m_wd3    = '0;
        m_isload = 1'b0;
    endtask

    task automatic model_advance();
        bit   full;
        bit   have;
        req_t w;
        if (rst) begin
            model_reset();
            return;
        end
        full = (q.size() == LQ_DEPTH);
        have = 1'b0;
        w    = '{rd: 0, data: '0, is_load: 1'b0};
        if (full || (!alu_valid && q.size() != 0)) begin
            w    = q.pop_front();
            have = 1'b1;
        end else if (alu_valid) begin
            w    = '{rd: int'(alu_rd), data: alu_data, is_load: 1'b0};
            have = 1'b1;
        end
        if (ld_valid && !full) begin
            q.push_back('{rd: int'(ld_rd), data: ld_data, is_load: 1'b1});
            outst[ld_rd] = 1'b0;
        end
        if (m_we && m_isload) pend[m_a3] = 1'b0;
        if (ld_issue && ld_issue_rd != 0) begin
            pend[ld_issue_rd]  = 1'b1;
            outst[ld_issue_rd] = 1'b1;
        end
        if (have && w.rd != 0) begin
            m_we     = 1'b1;
            m_a3     = w.rd;
            m_wd3    = w.data;
            m_isload = w.is_load;
        end else begin
            m_we = 1'b0;
        end
    endtask

    // Inputs are driven right after the falling edge; checking happens before the rising edge.
    task automatic step();
        #1;
        compare_cycle();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_issue  = 1'b0;
        ld_valid  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        alu_rd = '0; alu_data = '0; ld_issue_rd = '0; ld_rd = '0; ld_data = '0;
        rs1_addr = '0; rs2_addr = '0;

        // First edge brings the DUT out of X; model starts from its reset state.
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        step();
        rst = 1'b0;
        #1;
        chk("rst_we3", rf_we3, 0);
        chk("rst_a3", rf_a3, 0);
        chk("rst_wd3", rf_wd3, 0);
        chk("rst_count", lq_count, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);
        step();

        // ALU-only write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 chk("alu_accept", alu_ready, 1);
        step();
        idle();
        #1;
        chk("alu_we3", rf_we3, 1);
        chk("alu_a3", rf_a3, 5);
        chk("alu_wd3", rf_wd3, 32'hDEADBEEF);
        step();

        // x0 suppression
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234; rs1_addr = 5'd0;
        #1;
        chk("x0_accept", alu_ready, 1);
        chk("x0_rs1_busy", rs1_busy, 0);
        step();
        idle();
        #1 chk("x0_we3", rf_we3, 0);
        step();

        // Load hazard on rd 7
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        step();
        idle(); rs1_addr = 5'd7;
        #1 chk("hz_busy_pending", rs1_busy, 1);
        step();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hA5A5A5A5;
        #1 chk("hz_ld_ready", ld_ready, 1);
        step();
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            idle(); rs1_addr = 5'd7;
            #1;
            if (rf_we3 === 1'b1 && rf_a3 === 5'd7) begin
                seen = 1'b1;
                chk("hz_wd3", rf_wd3, 32'hA5A5A5A5);
                chk("hz_busy_inflight", rs1_busy, 1);
            end
            step();
        end
        chk("hz_write_seen", seen, 1);
        #1 chk("hz_busy_cleared", rs1_busy, 0);
        step();

        // Contention: ALU every cycle, two loads fill the queue
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        step();
        ld_issue_rd = 5'd4;
        step();
        idle();
        wr_log.delete();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        #1 chk("ct_alu_ready0", alu_ready, 1);
        step();
        alu_rd = 5'd11; alu_data = 32'h110;
        ld_rd = 5'd4; ld_data = 32'h44;
        #1 chk("ct_ld_ready1", ld_ready, 1);
        step();
        ld_valid = 1'b0; alu_rd = 5'd12; alu_data = 32'h120;
        #1;
        chk("ct_count_full", lq_count, 2);
        chk("ct_ld_ready_full", ld_ready, 0);
        chk("ct_alu_blocked", alu_ready, 0);
        step();
        #1 chk("ct_alu_resumes", alu_ready, 1);
        step();
        alu_rd = 5'd13; alu_data = 32'h130;
        step();
        idle();
        for (int i = 0; i < 5; i++) step();
        chk("ct_write_count", wr_log.size(), 6);
        if (wr_log.size() == 6) begin
            chk("ct_w0", wr_log[0], 10);
            chk("ct_w1", wr_log[1], 11);
            chk("ct_w2", wr_log[2], 3);
            chk("ct_w3", wr_log[3], 12);
            chk("ct_w4", wr_log[4], 13);
            chk("ct_w5", wr_log[5], 4);
        end
        alu_writes = 0;
        foreach (wr_log[k]) if (wr_log[k] >= 10) alu_writes++;
        chk("ct_alu_none_dropped", alu_writes, 4);

        // Simultaneous set and clear of rd 9
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        step();
        idle();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9999;
        step();
        idle();
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            idle();
            if (m_we && m_a3 == 9) begin
                ld_issue = 1'b1; ld_issue_rd = 5'd9; seen = 1'b1;
            end
            step();
        end
        chk("sc_clear_cycle_seen", seen, 1);
        idle(); rs1_addr = 5'd9;
        #1 chk("sc_busy_kept", rs1_busy, 1);
        step();

        // Reset with a full queue and pending loads
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        step();
        ld_issue_rd = 5'd5;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h140;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3030;
        step();
        ld_rd = 5'd5; ld_data = 32'h5050;
        step();
        idle(); rs1_addr = 5'd3; rs2_addr = 5'd5;
        #1;
        chk("rm_count_full", lq_count, 2);
        chk("rm_busy3", rs1_busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rm_we3", rf_we3, 0);
        chk("rm_count", lq_count, 0);
        chk("rm_ld_ready", ld_ready, 1);
        chk("rm_alu_ready", alu_ready, 1);
        chk("rm_rs1_busy", rs1_busy, 0);
        chk("rm_rs2_busy", rs2_busy, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            #1 chk("rm_no_stale_write", rf_we3, 0);
            step();
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst       = ($urandom_range(0, 299) == 0);
            alu_valid = $urandom_range(0, 1);
            alu_rd    = REGW'($urandom_range(0, 31));
            alu_data  = $urandom;
            rs1_addr  = REGW'($urandom_range(0, 31));
            rs2_addr  = REGW'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 3) begin
                r = $urandom_range(0, 31);
                if (r == 0 || !pend[r]) begin
                    ld_issue    = 1'b1;
                    ld_issue_rd = REGW'(r);
                end
            end
            if ($urandom_range(0, 9) < 5) begin
                start  = $urandom_range(0, 31);
                picked = 1'b0;
                for (int k = 0; k < NR && !picked; k++) begin
                    idx = (start + k) % NR;
                    if (outst[idx]) begin
                        picked   = 1'b1;
                        ld_valid = 1'b1;
                        ld_rd    = REGW'(idx);
                        ld_data  = $urandom;
                    end
                end
            end
            step();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
